// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bp_pkg
// Purpose  : Shared types, 2-bit counter encodings and saturating update rule
//            for the BHT port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package bp_pkg;

   typedef enum logic [1:0] {
      S_INIT   = 2'd0,
      S_IDLE   = 2'd1,
      S_UPD_RD = 2'd2,
      S_UPD_WR = 2'd3
   } bp_state_t;

   localparam logic [1:0] C_SNT = 2'b00;
   localparam logic [1:0] C_WNT = 2'b01;
   localparam logic [1:0] C_WT  = 2'b10;
   localparam logic [1:0] C_ST  = 2'b11;

   // Saturating 2-bit counter step; pinned at both ends, never wraps.
   function automatic logic [1:0] sat_next(input logic [1:0] ctr, input logic taken);
      if (taken)
         return (ctr == C_ST) ? C_ST : ctr + 2'd1;
      else
         return (ctr == C_SNT) ? C_SNT : ctr - 2'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bp_upd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bp_upd_fifo
// Purpose  : Synchronous show-ahead FIFO holding pending BHT updates, with an
//            occupancy count. Caller never pushes when full or pops when empty.
// Revision : 1.0 - initial release
// ============================================================================
module bp_upd_fifo #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (push)
         r_mem[r_wr_ptr] <= push_data;
   end

   // Depth is a power of two, so pointer overflow is the modulo wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push)
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (pop)
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign head  = r_mem[r_rd_ptr];
   assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/bht_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bht_port_arbiter
// Purpose  : Arbitrates the single BHT SRAM port between IF lookups and queued
//            MEM counter updates (read-modify-write), after a reset-time sweep.
// Revision : 1.0 - initial release
// ============================================================================
module bht_port_arbiter
   import bp_pkg::*;
#(
   parameter int         IDX_W     = 10,
   parameter int         DEPTH     = 1024,
   parameter int         UPD_DEPTH = 4,
   parameter logic [1:0] INIT_CTR  = 2'b01
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       lk_valid,
   input  logic [IDX_W-1:0]           lk_index,
   output logic                       lk_ready,
   output logic                       lk_rsp_valid,
   output logic [1:0]                 lk_ctr,
   output logic                       lk_taken,
   input  logic                       upd_valid,
   input  logic [IDX_W-1:0]           upd_index,
   input  logic                       upd_taken,
   output logic                       upd_ready,
   output logic [$clog2(UPD_DEPTH):0] upd_count,
   output logic                       tbl_en,
   output logic                       tbl_we,
   output logic [IDX_W-1:0]           tbl_addr,
   output logic [1:0]                 tbl_wdata,
   input  logic [1:0]                 tbl_rdata,
   output logic                       init_done
);

   localparam int CNT_W = $clog2(UPD_DEPTH) + 1;

   bp_state_t        r_state;
   logic [IDX_W-1:0] r_ptr;
   logic             r_init_done;
   logic             r_rsp_valid;

   logic [IDX_W:0]   w_head;
   logic [IDX_W-1:0] w_head_idx;
   logic             w_head_taken;
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;

   assign w_head_idx   = w_head[IDX_W:1];
   assign w_head_taken = w_head[0];
   assign w_full       = (upd_count == CNT_W'(UPD_DEPTH));
   assign w_empty      = (upd_count == '0);
   assign upd_ready    = ~rst & r_init_done & ~w_full;
   assign w_push       = upd_valid & upd_ready;
   assign w_pop        = ~rst & (r_state == S_UPD_RD);

   bp_upd_fifo #(
      .WIDTH (IDX_W + 1),
      .DEPTH (UPD_DEPTH),
      .CNT_W (CNT_W)
   ) u_upd_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (w_push),
      .push_data ({upd_index, upd_taken}),
      .pop       (w_pop),
      .head      (w_head),
      .count     (upd_count)
   );

   // Port drive is decoded from the current state so a lookup read issues in
   // the cycle it is accepted; rst forces the port quiet immediately.
   always_comb begin
      tbl_en    = 1'b0;
      tbl_we    = 1'b0;
      tbl_addr  = '0;
      tbl_wdata = 2'b00;
      lk_ready  = 1'b0;
      case (r_state)
         S_INIT: begin
            tbl_en    = 1'b1;
            tbl_we    = 1'b1;
            tbl_addr  = r_ptr;
            tbl_wdata = INIT_CTR;
         end
         S_IDLE: begin
            if (w_full) begin
               tbl_en   = 1'b1;
               tbl_addr = w_head_idx;
            end else if (lk_valid) begin
               lk_ready = 1'b1;
               tbl_en   = 1'b1;
               tbl_addr = lk_index;
            end else if (!w_empty) begin
               tbl_en   = 1'b1;
               tbl_addr = w_head_idx;
            end
         end
         S_UPD_RD: begin
            tbl_en    = 1'b1;
            tbl_we    = 1'b1;
            tbl_addr  = w_head_idx;
            tbl_wdata = sat_next(tbl_rdata, w_head_taken);
         end
         default: begin
         end
      endcase
      if (rst) begin
         tbl_en   = 1'b0;
         tbl_we   = 1'b0;
         lk_ready = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_INIT;
         r_ptr       <= '0;
         r_init_done <= 1'b0;
         r_rsp_valid <= 1'b0;
      end else begin
         r_rsp_valid <= lk_valid & lk_ready;
         case (r_state)
            S_INIT: begin
               r_ptr <= r_ptr + IDX_W'(1);
               if (r_ptr == IDX_W'(DEPTH - 1)) begin
                  r_state     <= S_IDLE;
                  r_init_done <= 1'b1;
               end
            end
            S_IDLE: begin
               if (w_full || (!lk_valid && !w_empty))
                  r_state <= S_UPD_RD;
            end
            S_UPD_RD: r_state <= S_UPD_WR;
            S_UPD_WR: r_state <= S_IDLE;
            default:  r_state <= S_INIT;
         endcase
      end
   end

   assign init_done    = r_init_done;
   assign lk_rsp_valid = r_rsp_valid;
   assign lk_ctr       = r_rsp_valid ? tbl_rdata : 2'b00;
   assign lk_taken     = lk_ctr[1];

endmodule
`default_nettype wire

// File: tb/tb_bht_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bht_port_arbiter
// Purpose  : Directed self-checking bench for bht_port_arbiter with an SRAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bht_port_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       lk_valid = 1'b0;
   logic [9:0] lk_index = '0;
   logic       lk_ready;
   logic       lk_rsp_valid;
   logic [1:0] lk_ctr;
   logic       lk_taken;
   logic       upd_valid = 1'b0;
   logic [9:0] upd_index = '0;
   logic       upd_taken = 1'b0;
   logic       upd_ready;
   logic [2:0] upd_count;
   logic       tbl_en;
   logic       tbl_we;
   logic [9:0] tbl_addr;
   logic [1:0] tbl_wdata;
   logic [1:0] tbl_rdata = 2'b00;
   logic       init_done;

   logic [1:0] mem [1024];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   bht_port_arbiter #(
      .IDX_W     (10),
      .DEPTH     (1024),
      .UPD_DEPTH (4),
      .INIT_CTR  (2'b01)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .lk_valid     (lk_valid),
      .lk_index     (lk_index),
      .lk_ready     (lk_ready),
      .lk_rsp_valid (lk_rsp_valid),
      .lk_ctr       (lk_ctr),
      .lk_taken     (lk_taken),
      .upd_valid    (upd_valid),
      .upd_index    (upd_index),
      .upd_taken    (upd_taken),
      .upd_ready    (upd_ready),
      .upd_count    (upd_count),
      .tbl_en       (tbl_en),
      .tbl_we       (tbl_we),
      .tbl_addr     (tbl_addr),
      .tbl_wdata    (tbl_wdata),
      .tbl_rdata    (tbl_rdata),
      .init_done    (init_done)
   );

   // SRAM model: write-or-read, read data valid the cycle after the read.
   always @(posedge clk) begin
      if (tbl_en) begin
         if (tbl_we)
            mem[tbl_addr] <= tbl_wdata;
         else
            tbl_rdata <= mem[tbl_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Entered in an IDLE cycle with a non-empty queue and no lookup pending.
   task automatic drain_one(input logic [9:0] idx, input logic [1:0] expw);
      #1;
      chk("drain_rd", 32'({tbl_en, tbl_we, tbl_addr}), 32'({2'b10, idx}));
      tick();
      #1;
      chk("drain_wr", 32'({tbl_en, tbl_we, tbl_addr, tbl_wdata}), 32'({2'b11, idx, expw}));
      tick();
      #1;
      chk("drain_gap", 32'(tbl_en), 32'(0));
      tick();
   endtask

   task automatic push_then_drain(input logic [9:0] idx, input logic tk, input logic [1:0] expw);
      upd_valid = 1'b1;
      upd_index = idx;
      upd_taken = tk;
      #1;
      chk("push_ready", 32'(upd_ready), 32'(1));
      chk("push_idle", 32'(tbl_en), 32'(0));
      tick();
      upd_valid = 1'b0;
      drain_one(idx, expw);
   endtask

   task automatic do_lookup(input logic [9:0] idx, input logic [1:0] expctr);
      lk_valid = 1'b1;
      lk_index = idx;
      #1;
      chk("lk_issue", 32'({lk_ready, tbl_en, tbl_we, tbl_addr}), 32'({3'b110, idx}));
      tick();
      lk_valid = 1'b0;
      #1;
      chk("lk_rsp", 32'({lk_rsp_valid, lk_ctr, lk_taken}), 32'({1'b1, expctr, expctr[1]}));
      tick();
   endtask

   initial begin
      // Reset cycle
      tick();
      #1;
      chk("rst_outs", 32'({lk_ready, lk_rsp_valid, lk_ctr, upd_ready, upd_count, init_done, tbl_en}),
          32'(0));
      tick();
      rst = 1'b0;
      lk_valid = 1'b1;
      lk_index = 10'd5;

      // Init sweep with a lookup pending the whole time
      for (int i = 0; i < 1024; i++) begin
         #1;
         chk("init_sweep",
             32'({tbl_en, tbl_we, tbl_addr, tbl_wdata, lk_ready, upd_ready, init_done, lk_rsp_valid}),
             32'({2'b11, 10'(i), 2'b01, 4'b0000}));
         tick();
      end
      lk_valid = 1'b0;
      #1;
      chk("init_done", 32'({init_done, upd_ready, tbl_en, lk_rsp_valid, upd_count}), 32'({4'b1100, 3'd0}));
      tick();

      do_lookup(10'd5, 2'b01);

      // Saturating update sequence on index 5
      push_then_drain(10'd5, 1'b1, 2'b10);
      push_then_drain(10'd5, 1'b1, 2'b11);
      do_lookup(10'd5, 2'b11);
      push_then_drain(10'd5, 1'b0, 2'b10);
      push_then_drain(10'd5, 1'b0, 2'b01);
      push_then_drain(10'd5, 1'b0, 2'b00);
      push_then_drain(10'd5, 1'b0, 2'b00);
      do_lookup(10'd5, 2'b00);

      // Fill the queue under continuous lookups
      for (int k = 0; k < 4; k++) begin
         lk_valid  = 1'b1;
         lk_index  = 10'd7;
         upd_valid = 1'b1;
         upd_index = 10'(10 + k);
         upd_taken = 1'b1;
         #1;
         chk("fill_lk_ready", 32'(lk_ready), 32'(1));
         chk("fill_upd_ready", 32'(upd_ready), 32'(1));
         chk("fill_count", 32'(upd_count), 32'(k));
         tick();
      end
      upd_valid = 1'b0;
      #1;
      chk("full_state", 32'({upd_count, upd_ready, lk_ready, lk_rsp_valid}), 32'({3'd4, 3'b001}));
      chk("full_rd", 32'({tbl_en, tbl_we, tbl_addr}), 32'({2'b10, 10'd10}));
      tick();
      #1;
      chk("stall_wr", 32'({lk_ready, tbl_en, tbl_we, tbl_addr, tbl_wdata}), 32'({3'b011, 10'd10, 2'b10}));
      chk("stall_rsp", 32'(lk_rsp_valid), 32'(0));
      tick();
      #1;
      chk("stall_gap", 32'({lk_ready, tbl_en, upd_count}), 32'({2'b00, 3'd3}));
      tick();
      #1;
      chk("stall_end", 32'({lk_ready, upd_count, tbl_en, tbl_we, tbl_addr}), 32'({1'b1, 3'd3, 2'b10, 10'd7}));
      tick();
      lk_valid = 1'b0;

      // Drain with a simultaneous enqueue and pop at count 2
      drain_one(10'd11, 2'b10);
      #1;
      chk("fifo_rd12", 32'({tbl_en, tbl_we, tbl_addr}), 32'({2'b10, 10'd12}));
      tick();
      upd_valid = 1'b1;
      upd_index = 10'd20;
      upd_taken = 1'b0;
      #1;
      chk("fifo_wr12", 32'({tbl_en, tbl_we, tbl_addr, tbl_wdata}), 32'({2'b11, 10'd12, 2'b10}));
      chk("pushpop_pre", 32'({upd_count, upd_ready}), 32'({3'd2, 1'b1}));
      tick();
      upd_valid = 1'b0;
      #1;
      chk("pushpop_cnt", 32'({upd_count, tbl_en}), 32'({3'd2, 1'b0}));
      tick();
      drain_one(10'd13, 2'b10);
      drain_one(10'd20, 2'b00);
      #1;
      chk("drained", 32'(upd_count), 32'(0));

      // Reset while an update write is due
      upd_valid = 1'b1;
      upd_index = 10'd30;
      upd_taken = 1'b1;
      tick();
      upd_index = 10'd31;
      #1;
      chk("rst_pre_rd", 32'({tbl_en, tbl_we, tbl_addr}), 32'({2'b10, 10'd30}));
      tick();
      upd_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_no_wr", 32'({tbl_en, upd_count}), 32'({1'b0, 3'd2}));
      tick();
      rst = 1'b0;
      #1;
      chk("resweep0", 32'({tbl_en, tbl_we, tbl_addr, tbl_wdata}), 32'({2'b11, 10'd0, 2'b01}));
      chk("rst_flush", 32'({upd_count, upd_ready, init_done, lk_rsp_valid}), 32'({3'd0, 3'b000}));
      chk("rst_mem30", 32'(mem[30]), 32'(2'b01));
      tick();
      #1;
      chk("resweep1", 32'({tbl_en, tbl_we, tbl_addr, tbl_wdata}), 32'({2'b11, 10'd1, 2'b01}));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bht_port_arbiter.md
# bht_port_arbiter

Owns the single read/write port of the 2-bit branch history table (BHT) SRAM. It arbitrates that port between IF-stage prediction lookups and MEM-stage counter updates. Updates are queued and drained as read-modify-write pairs in cycles when IF does not need the port. After every reset, the block sweeps the whole table to the weakly-not-taken value before it accepts any traffic.

## Interface
Parameters:
- IDX_W, 10, table index width
- DEPTH, 1024, table entries (must equal 2**IDX_W)
- UPD_DEPTH, 4, update queue entries (power of two, ≥2)
- INIT_CTR, 2'b01, counter value written by the init sweep

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- lk_valid  in  1  IF lookup request
- lk_index  in  IDX_W  lookup index (pc[11:2])
- lk_ready  out  1  lookup accepted this cycle
- lk_rsp_valid  out  1  lookup data valid
- lk_ctr  out  2  counter read
- lk_taken  out  1  lk_ctr[1]
- upd_valid  in  1  MEM update request (resolved branch)
- upd_index  in  IDX_W  update index (pc_M[11:2])
- upd_taken  in  1  resolved outcome
- upd_ready  out  1  queue can accept
- upd_count  out  $clog2(UPD_DEPTH)+1  queued entries
- tbl_en, tbl_we  out  1  SRAM enable / write enable
- tbl_addr  out  IDX_W  SRAM address
- tbl_wdata  out  2  SRAM write data
- tbl_rdata  in  2  SRAM read data, valid one cycle after a read
- init_done  out  1  sweep complete

## Operation
- FSM has four states: INIT, IDLE, UPD_RD, UPD_WR. Reset enters INIT with sweep pointer 0.
- **INIT:**
  - Each cycle: tbl_en=1, tbl_we=1, tbl_addr=ptr, tbl_wdata=INIT_CTR, then ptr++.
  - After writing DEPTH-1, go to IDLE and set init_done=1.
  - lk_ready=0 and upd_ready=0 throughout.
- **IDLE port priority:**
  1. Queue full (upd_count==UPD_DEPTH): lk_ready=0. Issue a read of the head index and go to UPD_RD.
  2. Else if lk_valid: lk_ready=1. Read lk_index (tbl_en=1, tbl_we=0).
  3. Else if queue non-empty: read the head index and go to UPD_RD.
  4. Else: port idle (tbl_en=0).
- **UPD_RD** (tbl_rdata now holds the head counter):
  - Write the head index with the new value: tbl_we=1, tbl_wdata=sat(tbl_rdata, head.taken).
  - Pop the head and go to UPD_WR.
  - lk_ready=0.
- **UPD_WR:** one recovery cycle with lk_ready=0 and the port idle, then IDLE. This keeps the read→write→read sequence on the same address hazard-free.
- Saturating counter rule:
  - taken: 00→01→10→11→11
  - not taken: 11→10→01→00→00
  - Arithmetic is 2-bit. It never wraps.
- Update queue:
  - FIFO order. upd_ready = init_done & (upd_count < UPD_DEPTH).
  - Enqueue and pop in the same cycle leave upd_count unchanged.
  - Read/write pointers wrap modulo UPD_DEPTH.
- There is no forwarding from the queue to lookups. A lookup may see a counter that still has updates queued; this staleness is defined and correct behaviour.
- Two queued updates to the same index are applied in order. Each is a full read-modify-write, so none is lost.

## Timing
- Reset values:
  - lk_ready=0, lk_rsp_valid=0, lk_ctr=0, upd_ready=0, upd_count=0, init_done=0.
  - tbl_en=0 during the rst cycle itself.
- Init latency: DEPTH cycles after rst deasserts. init_done rises in cycle DEPTH+1.
- Lookup latency: accepted in cycle t (lk_valid & lk_ready) → lk_rsp_valid=1 with lk_ctr in t+1. Otherwise lk_rsp_valid=0.
- Update drain occupies 3 cycles: IDLE read, UPD_RD write, UPD_WR.
- Worst-case lookup stall is 3 cycles, and occurs only when the queue is full.
- rst mid-drain or mid-sweep:
  - Queue is flushed and the in-flight write is abandoned.
  - The sweep restarts at 0.
  - lk_rsp_valid drops in the next cycle.

## Structure
- Package bp_pkg holds:
  - state enum (INIT, IDLE, UPD_RD, UPD_WR)
  - counter constants (SNT=00, WNT=01, WT=10, ST=11)
  - the sat_next(ctr, taken) function
- Sub-module bp_upd_fifo: synchronous FIFO, width IDX_W+1, depth UPD_DEPTH, with count output.

## Test plan
- Reset, then run 1024 cycles → 1024 writes of 2'b01 at addresses 0..1023 in order, init_done=1 at cycle 1025, no lookup accepted before that.
- Lookup index 5 after init → next cycle lk_rsp_valid=1, lk_ctr=01, lk_taken=0.
- Two taken updates to index 5 with no lookups → writes 10 then 11; a later lookup of 5 returns lk_ctr=11, lk_taken=1. Three further not-taken updates → 00. A fourth not-taken stays 00.
- lk_valid held high continuously with 4 updates enqueued → upd_ready=0 at count 4, lk_ready=0 for exactly 3 cycles, one drain occurs, lk_ready returns to 1, upd_count=3.
- Assert rst during UPD_RD with 2 entries queued → no write in the following cycle, upd_count=0, sweep restarts at address 0.
- Simultaneous enqueue and drain pop at count 2 → upd_count stays 2. Entries drain in FIFO order, verified by tbl_addr sequence.
